// File: rtl/pll_mgmt_pkg.sv
// Shared definitions for the PLL management responder: register map, FSM states
// and the two fractional-K settings used by the core's clock control.
package pll_mgmt_pkg;

  localparam logic [5:0] ADDR_MODE   = 6'd0;
  localparam logic [5:0] ADDR_STATUS = 6'd1;
  localparam logic [5:0] ADDR_START  = 6'd2;
  localparam logic [5:0] ADDR_N      = 6'd3;
  localparam logic [5:0] ADDR_M      = 6'd4;
  localparam logic [5:0] ADDR_C0     = 6'd5;
  localparam logic [5:0] ADDR_K      = 6'd7;

  localparam logic [31:0] K_NATIVE     = 32'd3639383488;
  localparam logic [31:0] K_UNDERCLOCK = 32'd3262113561;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD,
    APPLY,
    LOCK
  } state_t;

  function automatic logic [31:0] packStatus(input logic busy, input logic err);
    return {30'd0, err, busy};
  endfunction

endpackage

// File: rtl/pll_mgmt_regfile.sv
// Staging and active PLL setting registers, mode/error flags and the
// combinational read mux sampled by the responder FSM.
module pll_mgmt_regfile
  import pll_mgmt_pkg::*;
#(
  parameter logic [31:0] K_RESET = K_NATIVE
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic        i_wrEn,
  input  logic [5:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_apply,
  input  logic        i_setErr,
  input  logic        i_clrErr,
  input  logic        i_busy,
  output logic        o_mode,
  output logic [31:0] o_rdata,
  output logic [31:0] o_activeK,
  output logic [15:0] o_activeM,
  output logic [15:0] o_activeN,
  output logic [17:0] o_activeC0
);

  logic        r_mode;
  logic        r_err;
  logic [31:0] r_stgK;
  logic [15:0] r_stgM;
  logic [15:0] r_stgN;
  logic [17:0] r_stgC0;
  logic [31:0] r_actK;
  logic [15:0] r_actM;
  logic [15:0] r_actN;
  logic [17:0] r_actC0;

  // Staging is written freely; active only follows staging on the apply edge.
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      r_mode  <= 1'b0;
      r_err   <= 1'b0;
      r_stgK  <= K_RESET;
      r_stgM  <= 16'd0;
      r_stgN  <= 16'd0;
      r_stgC0 <= 18'd0;
      r_actK  <= K_RESET;
      r_actM  <= 16'd0;
      r_actN  <= 16'd0;
      r_actC0 <= 18'd0;
    end else begin
      if (i_wrEn) begin
        case (i_addr)
          ADDR_MODE: r_mode  <= i_wdata[0];
          ADDR_N:    r_stgN  <= i_wdata[15:0];
          ADDR_M:    r_stgM  <= i_wdata[15:0];
          ADDR_C0:   r_stgC0 <= i_wdata[17:0];
          ADDR_K:    r_stgK  <= i_wdata;
          default:   ;
        endcase
      end
      if (i_apply) begin
        r_actK  <= r_stgK;
        r_actM  <= r_stgM;
        r_actN  <= r_stgN;
        r_actC0 <= r_stgC0;
      end
      if (i_setErr) begin
        r_err <= 1'b1;
      end else if (i_clrErr) begin
        r_err <= 1'b0;
      end
    end
  end

  always_comb begin
    o_rdata = 32'd0;
    case (i_addr)
      ADDR_MODE:   o_rdata = {31'd0, r_mode};
      ADDR_STATUS: o_rdata = packStatus(i_busy, r_err);
      ADDR_N:      o_rdata = {16'd0, r_stgN};
      ADDR_M:      o_rdata = {16'd0, r_stgM};
      ADDR_C0:     o_rdata = {14'd0, r_stgC0};
      ADDR_K:      o_rdata = r_stgK;
      default:     o_rdata = 32'd0;
    endcase
  end

  assign o_mode     = r_mode;
  assign o_activeK  = r_actK;
  assign o_activeM  = r_actM;
  assign o_activeN  = r_actN;
  assign o_activeC0 = r_actC0;

endmodule

// File: rtl/pll_mgmt_responder.sv
// Avalon-MM target standing in for the PLL reconfig IP: accepts staged settings,
// applies them on a start command and models the relock interval.
module pll_mgmt_responder
  import pll_mgmt_pkg::*;
#(
  parameter int unsigned APPLY_CYCLES = 16,
  parameter int unsigned LOCK_CYCLES  = 64,
  parameter logic [31:0] K_RESET      = K_NATIVE
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic [5:0]  mgmt_address,
  input  logic        mgmt_write,
  input  logic [31:0] mgmt_writedata,
  input  logic        mgmt_read,
  output logic [31:0] mgmt_readdata,
  output logic        mgmt_waitrequest,
  output logic [31:0] active_k,
  output logic [15:0] active_m,
  output logic [15:0] active_n,
  output logic [17:0] active_c0,
  output logic        apply,
  output logic        locked,
  output logic        busy
);

  if (APPLY_CYCLES < 1 || LOCK_CYCLES < 1 ||
      APPLY_CYCLES > 65536 || LOCK_CYCLES > 65536) begin : gBadParams
    $error("pll_mgmt_responder: APPLY_CYCLES and LOCK_CYCLES must be in 1..65536");
  end

  localparam logic [15:0] APPLY_LOAD = 16'(APPLY_CYCLES - 1);
  localparam logic [15:0] LOCK_LOAD  = 16'(LOCK_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_wait;
  logic        r_rdPhase;
  logic [31:0] r_readdata;
  logic        r_apply;
  logic        r_locked;
  logic        r_busy;

  logic        w_wrDone;
  logic        w_rdStall;
  logic        w_rdDone;
  logic        w_start;
  logic        w_inFlight;
  logic        w_applyNow;
  logic        w_mode;
  logic [31:0] w_rdMux;

  // A fresh read is held off for one cycle so readdata can be registered; a
  // simultaneous write takes the transfer and the read is dropped.
  assign w_rdStall  = mgmt_read && !mgmt_write && !r_wait && !r_rdPhase;
  assign w_rdDone   = mgmt_read && !mgmt_write && !r_wait && r_rdPhase;
  assign w_wrDone   = mgmt_write && !r_wait;
  assign w_start    = w_wrDone && (mgmt_address == ADDR_START);
  assign w_inFlight = (r_state == APPLY) || (r_state == LOCK);
  assign w_applyNow = (r_state == APPLY) && (r_cnt == 16'd0);

  assign mgmt_waitrequest = r_wait || w_rdStall;
  assign mgmt_readdata    = r_readdata;
  assign apply            = r_apply;
  assign locked           = r_locked;
  assign busy             = r_busy;

  pll_mgmt_regfile #(
    .K_RESET (K_RESET)
  ) u_regfile (
    .clk_50m    (clk_50m),
    .reset      (reset),
    .i_wrEn     (w_wrDone && (mgmt_address != ADDR_START)),
    .i_addr     (mgmt_address),
    .i_wdata    (mgmt_writedata),
    .i_apply    (w_applyNow),
    .i_setErr   (w_start && w_inFlight),
    .i_clrErr   (w_rdDone && (mgmt_address == ADDR_STATUS)),
    .i_busy     (r_busy),
    .o_mode     (w_mode),
    .o_rdata    (w_rdMux),
    .o_activeK  (active_k),
    .o_activeM  (active_m),
    .o_activeN  (active_n),
    .o_activeC0 (active_c0)
  );

  // Waitrequest for an apply is chosen at the start edge, so a mode write made
  // while busy only affects the following start.
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      r_state    <= INIT;
      r_cnt      <= 16'd0;
      r_wait     <= 1'b1;
      r_rdPhase  <= 1'b0;
      r_readdata <= 32'd0;
      r_apply    <= 1'b0;
      r_locked   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_apply   <= 1'b0;
      r_rdPhase <= w_rdStall;
      if (w_rdStall) begin
        r_readdata <= w_rdMux;
      end
      case (r_state)
        INIT: begin
          r_wait   <= 1'b0;
          r_locked <= 1'b1;
          r_state  <= IDLE;
        end
        IDLE, RD: begin
          if (w_start) begin
            r_state <= APPLY;
            r_cnt   <= APPLY_LOAD;
            r_busy  <= 1'b1;
            r_wait  <= !w_mode;
          end else if (w_rdStall) begin
            r_state <= RD;
          end else begin
            r_state <= IDLE;
          end
        end
        APPLY: begin
          if (r_cnt == 16'd0) begin
            r_apply  <= 1'b1;
            r_locked <= 1'b0;
            r_cnt    <= LOCK_LOAD;
            r_state  <= LOCK;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        LOCK: begin
          if (r_cnt == 16'd0) begin
            r_locked <= 1'b1;
            r_busy   <= 1'b0;
            r_wait   <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= INIT;
          r_wait  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_mgmt_responder.sv
// Scoreboard bench for pll_mgmt_responder: stimulus queues expected read data and
// apply snapshots, a negedge monitor pops them when the DUT presents them.
module tb_pll_mgmt_responder;
  import pll_mgmt_pkg::*;

  logic        clk_50m = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  mgmt_address = 6'd0;
  logic        mgmt_write = 1'b0;
  logic [31:0] mgmt_writedata = 32'd0;
  logic        mgmt_read = 1'b0;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;
  logic [31:0] active_k;
  logic [15:0] active_m;
  logic [15:0] active_n;
  logic [17:0] active_c0;
  logic        apply;
  logic        locked;
  logic        busy;

  typedef struct packed {
    logic [31:0] k;
    logic [15:0] m;
    logic [15:0] n;
    logic [17:0] c0;
  } applyRec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] rdQ[$];
  applyRec_t   applyQ[$];

  pll_mgmt_responder dut (
    .clk_50m          (clk_50m),
    .reset            (reset),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_read        (mgmt_read),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .active_k         (active_k),
    .active_m         (active_m),
    .active_n         (active_n),
    .active_c0        (active_c0),
    .apply            (apply),
    .locked           (locked),
    .busy             (busy)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Both bus tasks are entered just after a rising edge and return just after one.
  task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data, output int waits);
    mgmt_address   = addr;
    mgmt_writedata = data;
    mgmt_write     = 1'b1;
    waits = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_50m);
      if (!mgmt_waitrequest) break;
      waits++;
    end
    if (waits >= 300) checkOutput("write timeout", 32'(waits), 32'd0);
    @(posedge clk_50m);
    #1;
    mgmt_write = 1'b0;
  endtask

  task automatic applyRead(input logic [5:0] addr, input logic [31:0] exp, output int waits);
    rdQ.push_back(exp);
    mgmt_address = addr;
    mgmt_read    = 1'b1;
    waits = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_50m);
      if (!mgmt_waitrequest) break;
      waits++;
    end
    if (waits >= 300) checkOutput("read timeout", 32'(waits), 32'd0);
    @(posedge clk_50m);
    #1;
    mgmt_read = 1'b0;
  endtask

  task automatic watchBusy(output int busyHi, output int waitHi, output int lockLow,
                           output int applyCnt, output int applyAt);
    busyHi = 0; waitHi = 0; lockLow = 0; applyCnt = 0; applyAt = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_50m);
      if (!busy) break;
      busyHi++;
      if (mgmt_waitrequest) waitHi++;
      if (!locked) lockLow++;
      if (apply) begin
        applyCnt++;
        applyAt = c;
      end
    end
    @(posedge clk_50m);
    #1;
  endtask

  // Monitor: compares every completed read and every apply strobe.
  always @(negedge clk_50m) begin
    if (reset) begin
      if (mgmt_read && !mgmt_write && !mgmt_waitrequest) begin
        if (rdQ.size() == 0) begin
          checkOutput("unexpected read", mgmt_readdata, 32'hFFFF_FFFF);
        end else begin
          checkOutput("readdata", mgmt_readdata, rdQ.pop_front());
        end
      end
      if (apply) begin
        if (applyQ.size() == 0) begin
          checkOutput("unexpected apply", 32'd1, 32'd0);
        end else begin
          applyRec_t exp;
          exp = applyQ.pop_front();
          checkOutput("apply active_k", active_k, exp.k);
          checkOutput("apply active_m", {16'd0, active_m}, {16'd0, exp.m});
          checkOutput("apply active_n", {16'd0, active_n}, {16'd0, exp.n});
          checkOutput("apply active_c0", {14'd0, active_c0}, {14'd0, exp.c0});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int w, busyHi, waitHi, lockLow, applyCnt, applyAt;

    $display("[TB] reset release");
    repeat (3) @(posedge clk_50m);
    #1;
    reset = 1'b1;
    @(negedge clk_50m);
    checkOutput("init waitrequest", {31'd0, mgmt_waitrequest}, 32'd1);
    checkOutput("init locked", {31'd0, locked}, 32'd0);
    checkOutput("init active_k", active_k, K_NATIVE);
    checkOutput("init readdata", mgmt_readdata, 32'd0);
    checkOutput("init busy", {31'd0, busy}, 32'd0);
    @(negedge clk_50m);
    checkOutput("idle waitrequest", {31'd0, mgmt_waitrequest}, 32'd0);
    checkOutput("idle locked", {31'd0, locked}, 32'd1);
    @(posedge clk_50m);
    #1;
    applyRead(ADDR_K, K_NATIVE, w);
    checkOutput("read wait cycles", 32'(w), 32'd1);

    $display("[TB] waitrequest-mode underclock apply");
    applyStimulus(ADDR_MODE, 32'd0, w);
    checkOutput("write wait cycles", 32'(w), 32'd0);
    applyStimulus(ADDR_K, K_UNDERCLOCK, w);
    applyQ.push_back('{k: K_UNDERCLOCK, m: 16'd0, n: 16'd0, c0: 18'd0});
    applyStimulus(ADDR_START, 32'd0, w);
    watchBusy(busyHi, waitHi, lockLow, applyCnt, applyAt);
    checkOutput("wr-mode busy cycles", 32'(busyHi), 32'd80);
    checkOutput("wr-mode wait cycles", 32'(waitHi), 32'd80);
    checkOutput("wr-mode locked low", 32'(lockLow), 32'd64);
    checkOutput("wr-mode apply count", 32'(applyCnt), 32'd1);
    checkOutput("wr-mode apply cycle", 32'(applyAt), 32'd16);
    checkOutput("wr-mode active_k", active_k, K_UNDERCLOCK);
    checkOutput("wr-mode locked end", {31'd0, locked}, 32'd1);

    $display("[TB] polling-mode apply");
    applyStimulus(ADDR_MODE, 32'd1, w);
    applyStimulus(ADDR_M, 32'h0000_0123, w);
    applyQ.push_back('{k: K_UNDERCLOCK, m: 16'h0123, n: 16'd0, c0: 18'd0});
    applyStimulus(ADDR_START, 32'd0, w);
    for (int k = 0; k < 42; k++) begin
      applyRead(ADDR_STATUS, (2 * k < 80) ? 32'd1 : 32'd0, w);
      checkOutput("poll read wait", 32'(w), 32'd1);
    end
    checkOutput("poll active_m", {16'd0, active_m}, 32'h0000_0123);

    $display("[TB] start while busy");
    applyQ.push_back('{k: K_UNDERCLOCK, m: 16'h0123, n: 16'd0, c0: 18'd0});
    applyStimulus(ADDR_START, 32'd0, w);
    repeat (5) @(posedge clk_50m);
    #1;
    applyStimulus(ADDR_START, 32'd0, w);
    checkOutput("busy start wait", 32'(w), 32'd0);
    watchBusy(busyHi, waitHi, lockLow, applyCnt, applyAt);
    checkOutput("busy start apply count", 32'(applyCnt), 32'd1);
    checkOutput("busy start wait cycles", 32'(waitHi), 32'd0);
    applyRead(ADDR_STATUS, 32'd2, w);
    applyRead(ADDR_STATUS, 32'd0, w);

    $display("[TB] simultaneous read and write");
    mgmt_address   = ADDR_N;
    mgmt_writedata = 32'h0000_0055;
    mgmt_write     = 1'b1;
    mgmt_read      = 1'b1;
    @(negedge clk_50m);
    checkOutput("rw waitrequest", {31'd0, mgmt_waitrequest}, 32'd0);
    @(posedge clk_50m);
    #1;
    mgmt_write = 1'b0;
    mgmt_read  = 1'b0;
    checkOutput("rw readdata held", mgmt_readdata, 32'd0);
    applyRead(ADDR_N, 32'h0000_0055, w);

    $display("[TB] reset during apply");
    applyStimulus(ADDR_MODE, 32'd0, w);
    applyStimulus(ADDR_START, 32'd0, w);
    for (int c = 0; c < 10; c++) @(negedge clk_50m);
    @(negedge clk_50m);
    reset = 1'b0;
    #1;
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst waitrequest", {31'd0, mgmt_waitrequest}, 32'd1);
    checkOutput("rst active_k", active_k, K_NATIVE);
    checkOutput("rst locked", {31'd0, locked}, 32'd0);
    repeat (2) @(negedge clk_50m);
    checkOutput("rst held waitrequest", {31'd0, mgmt_waitrequest}, 32'd1);
    @(posedge clk_50m);
    #1;
    reset = 1'b1;
    @(negedge clk_50m);
    checkOutput("rst init waitrequest", {31'd0, mgmt_waitrequest}, 32'd1);
    @(negedge clk_50m);
    checkOutput("rst idle waitrequest", {31'd0, mgmt_waitrequest}, 32'd0);
    applyCnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_50m);
      if (apply) applyCnt++;
    end
    checkOutput("rst apply count", 32'(applyCnt), 32'd0);
    checkOutput("rst busy after", {31'd0, busy}, 32'd0);
    @(posedge clk_50m);
    #1;
    applyRead(ADDR_K, K_NATIVE, w);

    repeat (2) @(posedge clk_50m);
    checkOutput("read queue drained", 32'(rdQ.size()), 32'd0);
    checkOutput("apply queue drained", 32'(applyQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
